// File: rtl/sa_pkg.sv
// ============================================================================
// Module : sa_pkg
// Brief  : Shared types and constants for the bit-serial systolic array:
//          FSM state encoding, maximum weight precision, precision field
//          width and a helper that qualifies a precision value.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sa_pkg;

  // Largest weight precision the array is built for, and the width of the
  // precision / bit-index fields that travel through the array.
  localparam int MAX_PREC = 8;
  localparam int PREC_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } sa_state_t;

  // A precision is usable when it is non-zero and no larger than the
  // configured maximum.
  function automatic logic prec_legal(input logic [PREC_W-1:0] p,
                                      input int max_prec);
    return (p != '0) && (int'(p) <= max_prec);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sa_pe.sv
// ============================================================================
// Module : sa_pe
// Brief  : Output-stationary bit-serial MAC cell. Each valid beat adds the
//          activation, shifted by its bit weight, when the weight bit is set;
//          the first bit of an element is the two's-complement sign bit and
//          its term is subtracted. Activation, valid and bit index are
//          registered to the right neighbour, the weight bit to the cell
//          below.
// Ports  : clk, rst (sync, active-low), clr (accumulator clear),
//          prec (job precision), act/vld/idx/wbit (inputs from left/above),
//          act_pass/vld_pass/idx_pass/wbit_pass (to right/below), acc.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_pe
  import sa_pkg::*;
#(
  parameter int ACT_WIDTH = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic [PREC_W-1:0]           prec,
  input  logic signed [ACT_WIDTH-1:0] act,
  input  logic                        vld,
  input  logic [PREC_W-1:0]           idx,
  input  logic                        wbit,
  output logic signed [ACT_WIDTH-1:0] act_pass,
  output logic                        vld_pass,
  output logic [PREC_W-1:0]           idx_pass,
  output logic                        wbit_pass,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [ACC_WIDTH-1:0] act_ext;
  logic signed [ACC_WIDTH-1:0] term;
  logic [PREC_W-1:0]           shamt;

  // Bit idx (0 = MSB) carries weight 2^(prec-1-idx).
  always_comb begin
    act_ext = ACC_WIDTH'(act);
    shamt   = prec - idx - PREC_W'(1);
    term    = act_ext <<< shamt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      act_pass  <= '0;
      vld_pass  <= 1'b0;
      idx_pass  <= '0;
      wbit_pass <= 1'b0;
      acc       <= '0;
    end else begin
      act_pass  <= act;
      vld_pass  <= vld;
      idx_pass  <= idx;
      wbit_pass <= wbit;
      if (clr) begin
        acc <= '0;
      end else if (vld && wbit) begin
        if (idx == '0) begin
          acc <= acc - term;
        end else begin
          acc <= acc + term;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/systolic_array_v2.sv
// ============================================================================
// Module : systolic_array_v2
// Brief  : ROWS x COLS output-stationary systolic array computing
//          C = A * W with bit-serial (MSB-first, two's complement) weights.
//          One beat carries one activation per row and one weight bit per
//          column; inputs are skewed so that row i and column j meet at
//          PE(i,j) i+j cycles after entry. Results are read out row-major.
// Ports  : clk, rst (sync, active-low)
//          start/precision/k_len        : job launch (sampled in IDLE)
//          act_valid/act_ready/act_in/w_in : beat stream
//          busy, err (bad-start pulse), done (job-complete pulse)
//          out_valid/out_ready/out_data/out_row/out_col : result stream
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_array_v2 #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int ACT_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int MAX_PREC  = sa_pkg::MAX_PREC
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [sa_pkg::PREC_W-1:0]              precision,
  input  logic [15:0]                            k_len,
  input  logic                                   act_valid,
  output logic                                   act_ready,
  input  logic [ROWS*ACT_WIDTH-1:0]              act_in,
  input  logic [COLS-1:0]                        w_in,
  output logic                                   busy,
  output logic                                   err,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ACC_WIDTH-1:0]                   out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] out_col,
  output logic                                   done
);

  import sa_pkg::*;

  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DRAIN_LEN = ROWS + COLS - 1;
  localparam int DW        = $clog2(DRAIN_LEN + 1);

  sa_state_t state, state_nx;

  logic [PREC_W-1:0] prec_q;
  logic [PREC_W-1:0] bit_idx;
  logic [15:0]       k_len_q;
  logic [15:0]       k_cnt;
  logic [DW-1:0]     drain_cnt;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic              err_q;
  logic              done_q;

  logic start_ok;
  logic start_bad;
  logic beat;
  logic last_beat;
  logic out_fire;
  logic out_last;
  logic clr;

  // Edge-of-array streams and the PE mesh interconnect.
  logic signed [ACT_WIDTH-1:0] row_act [ROWS];
  logic                        row_vld [ROWS];
  logic [PREC_W-1:0]           row_idx [ROWS];
  logic                        col_w   [COLS];

  logic signed [ACT_WIDTH-1:0] h_act [ROWS][COLS];
  logic                        h_vld [ROWS][COLS];
  logic [PREC_W-1:0]           h_idx [ROWS][COLS];
  logic                        v_w   [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0] acc_arr [ROWS][COLS];

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  always_comb begin
    start_ok  = (state == ST_IDLE) && start && prec_legal(precision, MAX_PREC);
    start_bad = (state == ST_IDLE) && start && !prec_legal(precision, MAX_PREC);
    beat      = (state == ST_FEED) && act_valid;
    last_beat = beat && (bit_idx == prec_q - PREC_W'(1)) &&
                (k_cnt == k_len_q - 16'd1);
    out_fire  = (state == ST_OUT) && out_ready;
    out_last  = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
    clr       = start_ok;
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    act_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          // An empty reduction has nothing to feed; results are the cleared
          // accumulators.
          state_nx = (k_len == 16'd0) ? ST_OUT : ST_FEED;
        end
      end
      ST_FEED: begin
        busy      = 1'b1;
        act_ready = 1'b1;
        if (last_beat) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DW'(DRAIN_LEN - 1)) begin
          state_nx = ST_OUT;
        end
      end
      ST_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_fire && out_last) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Job counters and pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      prec_q    <= '0;
      k_len_q   <= '0;
      bit_idx   <= '0;
      k_cnt     <= '0;
      drain_cnt <= '0;
      row_q     <= '0;
      col_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      err_q  <= start_bad;
      done_q <= out_fire && out_last;
      if (start_ok) begin
        prec_q    <= precision;
        k_len_q   <= k_len;
        bit_idx   <= '0;
        k_cnt     <= '0;
        drain_cnt <= '0;
        row_q     <= '0;
        col_q     <= '0;
      end
      if (beat) begin
        if (bit_idx == prec_q - PREC_W'(1)) begin
          bit_idx <= '0;
          k_cnt   <= k_cnt + 16'd1;
        end else begin
          bit_idx <= bit_idx + PREC_W'(1);
        end
      end
      if (state == ST_DRAIN) begin
        drain_cnt <= drain_cnt + DW'(1);
      end
      if (out_fire) begin
        if (col_q == CW'(COLS - 1)) begin
          col_q <= '0;
          row_q <= out_last ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  assign err  = err_q;
  assign done = done_q;

  // --------------------------------------------------------------------------
  // Row skew: the activation is taken only on bit 0 of an element and held
  // for the remaining bits, so every beat in the array carries its element's
  // activation. Stage 0 registers the beat; row r adds r more stages.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic signed [ACT_WIDTH-1:0] act_hold;
    logic signed [ACT_WIDTH-1:0] act_cur;
    logic signed [ACT_WIDTH-1:0] a_sr [0:r];
    logic                        v_sr [0:r];
    logic [PREC_W-1:0]           i_sr [0:r];

    assign act_cur = (bit_idx == '0) ? act_in[r*ACT_WIDTH +: ACT_WIDTH] : act_hold;

    always_ff @(posedge clk) begin
      if (!rst) begin
        act_hold <= '0;
        for (int k = 0; k <= r; k++) begin
          a_sr[k] <= '0;
          v_sr[k] <= 1'b0;
          i_sr[k] <= '0;
        end
      end else begin
        if (beat && (bit_idx == '0)) begin
          act_hold <= act_in[r*ACT_WIDTH +: ACT_WIDTH];
        end
        a_sr[0] <= act_cur;
        v_sr[0] <= beat;
        i_sr[0] <= bit_idx;
        for (int k = 1; k <= r; k++) begin
          a_sr[k] <= a_sr[k-1];
          v_sr[k] <= v_sr[k-1];
          i_sr[k] <= i_sr[k-1];
        end
      end
    end

    assign row_act[r] = a_sr[r];
    assign row_vld[r] = v_sr[r];
    assign row_idx[r] = i_sr[r];
  end

  // Column skew: column c weight bit delayed by c stages after stage 0.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic w_sr [0:c];

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int k = 0; k <= c; k++) begin
          w_sr[k] <= 1'b0;
        end
      end else begin
        w_sr[0] <= w_in[c];
        for (int k = 1; k <= c; k++) begin
          w_sr[k] <= w_sr[k-1];
        end
      end
    end

    assign col_w[c] = w_sr[c];
  end

  // --------------------------------------------------------------------------
  // PE mesh
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe_col
      logic signed [ACT_WIDTH-1:0] a_i;
      logic                        v_i;
      logic [PREC_W-1:0]           x_i;
      logic                        w_i;

      if (c == 0) begin : g_left
        assign a_i = row_act[r];
        assign v_i = row_vld[r];
        assign x_i = row_idx[r];
      end else begin : g_inner_h
        assign a_i = h_act[r][c-1];
        assign v_i = h_vld[r][c-1];
        assign x_i = h_idx[r][c-1];
      end

      if (r == 0) begin : g_top
        assign w_i = col_w[c];
      end else begin : g_inner_v
        assign w_i = v_w[r-1][c];
      end

      sa_pe #(
        .ACT_WIDTH (ACT_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .prec      (prec_q),
        .act       (a_i),
        .vld       (v_i),
        .idx       (x_i),
        .wbit      (w_i),
        .act_pass  (h_act[r][c]),
        .vld_pass  (h_vld[r][c]),
        .idx_pass  (h_idx[r][c]),
        .wbit_pass (v_w[r][c]),
        .acc       (acc_arr[r][c])
      );
    end
  end

  // --------------------------------------------------------------------------
  // Result port
  // --------------------------------------------------------------------------
  always_comb begin
    out_data = (state == ST_OUT) ? acc_arr[row_q][col_q] : '0;
  end

  assign out_row = row_q;
  assign out_col = col_q;

endmodule

`default_nettype wire

// File: tb/tb_systolic_array_v2.sv
// ============================================================================
// Module : tb_systolic_array_v2
// Brief  : Self-checking bench for systolic_array_v2 (2x2, 16-bit acts,
//          32-bit accumulators). Operand matrices are drawn at random, the
//          expected product is formed with plain integer arithmetic and the
//          streamed results are compared in row-major order.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_systolic_array_v2;

  localparam int ROWS      = 2;
  localparam int COLS      = 2;
  localparam int ACT_WIDTH = 16;
  localparam int ACC_WIDTH = 32;
  localparam int MAX_PREC  = 8;
  localparam int KMAX      = 8;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      start = 1'b0;
  logic [3:0]                precision = '0;
  logic [15:0]               k_len = '0;
  logic                      act_valid = 1'b0;
  logic                      act_ready;
  logic [ROWS*ACT_WIDTH-1:0] act_in = '0;
  logic [COLS-1:0]           w_in = '0;
  logic                      busy;
  logic                      err;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [ACC_WIDTH-1:0]      out_data;
  logic [0:0]                out_row;
  logic [0:0]                out_col;
  logic                      done;

  int n_checks = 0;
  int n_pass   = 0;

  shortint a_m   [ROWS][KMAX];
  int      w_m   [KMAX][COLS];
  int      exp_c [ROWS][COLS];

  systolic_array_v2 #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .ACT_WIDTH (ACT_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .MAX_PREC  (MAX_PREC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .precision (precision),
    .k_len     (k_len),
    .act_valid (act_valid),
    .act_ready (act_ready),
    .act_in    (act_in),
    .w_in      (w_in),
    .busy      (busy),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, expected completion)");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference product: C = A * W, wrapping at 32 bits like the accumulators.
  task automatic compute_expected(input int klen);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
        int s = 0;
        for (int k = 0; k < klen; k++) s += int'(a_m[i][k]) * w_m[k][j];
        exp_c[i][j] = s;
      end
  endtask

  task automatic rand_operands(input int prec, input int klen);
    for (int k = 0; k < klen; k++) begin
      for (int i = 0; i < ROWS; i++) a_m[i][k] = shortint'($urandom);
      for (int j = 0; j < COLS; j++)
        w_m[k][j] = int'($urandom_range(0, (1 << prec) - 1)) - (1 << (prec - 1));
    end
  endtask

  task automatic run_job(input int prec, input int klen, input int gap_pct,
                         input int stall_pct, input int stall_on, input bit poke);
    int beats, cyc, res_i, stall_left;
    bit accepted, pchk;
    start = 1'b1; precision = 4'(prec); k_len = 16'(klen);
    tick();
    start = 1'b0; precision = 4'($urandom); k_len = 16'($urandom);
    check("busy_after_start", busy, 1);
    if (klen > 0) begin
      beats = 0; cyc = 0; pchk = 1'b0;
      while (beats < klen * prec && cyc < 5000) begin
        int k = beats / prec;
        int b = beats % prec;
        act_valid = ($urandom_range(0, 99) >= gap_pct);
        for (int i = 0; i < ROWS; i++)
          act_in[i*ACT_WIDTH +: ACT_WIDTH] = (b == 0 && act_valid) ? 16'(a_m[i][k]) : 16'($urandom);
        for (int j = 0; j < COLS; j++)
          w_in[j] = 1'((w_m[k][j] >> (prec - 1 - b)) & 1);
        if (poke && beats == 1 && !pchk && n_checks >= 0) begin
          start = 1'b1; precision = 4'd0; pchk = 1'b1;
        end
        accepted = act_valid && act_ready;
        tick(); cyc++;
        if (start) begin
          start = 1'b0;
          check("start_in_feed_err", err, 0);
          check("start_in_feed_busy", busy, 1);
        end
        if (accepted) beats++;
      end
      act_valid = 1'b0;
      check("feed_beats", beats, klen * prec);
      check("act_ready_after_feed", act_ready, 0);
      cyc = 0;
      while (!out_valid && cyc < 100) begin tick(); cyc++; end
      check("drain_len", cyc, ROWS + COLS - 1);
    end else begin
      check("kzero_out_valid", out_valid, 1);
    end
    res_i = 0; cyc = 0; stall_left = 5;
    while (res_i < ROWS * COLS && cyc < 2000) begin
      if (res_i == stall_on && stall_left > 0) begin
        out_ready = 1'b0;
        check("stall_valid", out_valid, 1);
        check("stall_data", $signed(out_data), exp_c[res_i / COLS][res_i % COLS]);
        stall_left--;
      end else begin
        out_ready = ($urandom_range(0, 99) >= stall_pct);
        if (out_valid && out_ready) begin
          check("out_row", out_row, res_i / COLS);
          check("out_col", out_col, res_i % COLS);
          check("out_data", $signed(out_data), exp_c[res_i / COLS][res_i % COLS]);
          res_i++;
        end
      end
      tick(); cyc++;
    end
    out_ready = 1'b0;
    check("results_count", res_i, ROWS * COLS);
    check("done_pulse", done, 1);
    check("busy_end", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_act_ready", act_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    rst = 1'b1;
    tick();

    // Directed 2x2 example: A=[3,-2], W=[5,-1]
    a_m[0][0] = 16'sd3; a_m[1][0] = -16'sd2;
    w_m[0][0] = 5;      w_m[0][1] = -1;
    exp_c[0][0] = 15; exp_c[0][1] = -3; exp_c[1][0] = -10; exp_c[1][1] = 2;
    run_job(4, 1, 0, 0, -1, 1'b0);

    // Same job, second result back-pressured for 5 cycles
    run_job(4, 1, 0, 0, 1, 1'b0);

    // Illegal precisions
    start = 1'b1; precision = 4'd0; k_len = 16'd1;
    tick();
    start = 1'b0;
    check("err_prec0", err, 1);
    check("busy_prec0", busy, 0);
    tick();
    check("err_prec0_clear", err, 0);
    check("busy_prec0_idle", busy, 0);
    start = 1'b1; precision = 4'd9;
    tick();
    start = 1'b0;
    check("err_prec9", err, 1);
    check("busy_prec9", busy, 0);
    tick();

    // Randomized jobs with gaps and output back-pressure
    for (int it = 0; it < 6; it++) begin
      int p = (it < 3) ? 8 : int'($urandom_range(1, 8));
      int kl = (it < 3) ? 3 : int'($urandom_range(1, KMAX));
      rand_operands(p, kl);
      compute_expected(kl);
      run_job(p, kl, 30, 30, -1, it == 0);
    end

    // Reset in the middle of FEED
    start = 1'b1; precision = 4'd8; k_len = 16'd3;
    tick();
    start = 1'b0; act_valid = 1'b1;
    repeat (5) tick();
    act_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_act_ready", act_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    rst = 1'b1;
    tick();
    rand_operands(8, 3);
    compute_expected(3);
    run_job(8, 3, 20, 20, -1, 1'b0);

    // Empty reduction
    compute_expected(0);
    run_job(5, 0, 0, 20, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
